vga_sync_gen: RTL and testbench

//   Generates 640x480@60Hz VGA raster timing for the pong graphics pipeline.

---
 rtl/vga_sync_gen_pkg.sv | 57 +++++
 rtl/vga_sync_gen_mod_m_counter.sv | 48 ++++
 rtl/vga_sync_gen.sv | 122 ++++++++++++
 tb/tb_vga_sync_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// ---------------------------------------------------------------------------
// vga_sync_gen_pkg
//   Shared raster-timing constants and helpers for the VGA sync generator and
//   the pong graphics stage downstream of it. The defaults describe
//   640x480@60Hz with a 100 MHz system clock divided down to a 25 MHz pixel
//   rate. Derived totals and sync windows are exported so the graphics stage
//   can size its own MAX_X/MAX_Y from the same numbers.
//
//   Contents:
//     DEF_*        default timing parameters (pixels / lines / clocks)
//     H_TOTAL_DEF  pixels per line, V_TOTAL_DEF lines per frame
//     *_SYNC_START/END  inclusive sync windows for the default timing
//     CNT_W        width of the raster counters
//     vga_ctrl_t   bundle of the registered video_on/hsync/vsync bits
//     in_window()  inclusive range test on a raster count
//     cnt_width()  counter width needed for a modulus (minimum 1 bit)
// ---------------------------------------------------------------------------
package vga_sync_gen_pkg;

  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_H_DISP  = 640;
  localparam int DEF_H_FP    = 16;
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BP    = 48;
  localparam int DEF_V_DISP  = 480;
  localparam int DEF_V_FP    = 10;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BP    = 33;

  localparam int H_TOTAL_DEF = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL_DEF = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int H_SYNC_START_DEF = DEF_H_DISP + DEF_H_FP;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + DEF_H_SYNC - 1;
  localparam int V_SYNC_START_DEF = DEF_V_DISP + DEF_V_FP;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + DEF_V_SYNC - 1;

  localparam int CNT_W = 10;

  typedef struct packed {
    logic video_on;
    logic hsync;
    logic vsync;
  } vga_ctrl_t;

  // Inclusive window test; the count is zero-extended before comparing.
  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

  // A modulus of 1 still needs a 1-bit counter register.
  function automatic int cnt_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/vga_sync_gen_mod_m_counter.sv
// ---------------------------------------------------------------------------
// mod_m_counter
//   Free-running modulo-M counter used as the pixel-rate divider. The count
//   runs 0..M-1 and wraps by explicit compare. tick_o is a registered pulse,
//   one clock wide, appearing every M clocks; the first tick arrives M clocks
//   after reset is released. tick_next_o is the value tick_o will take at the
//   next clock edge, for logic that must register outputs aligned with tick_o.
//
//   Ports:
//     clk_i        system clock
//     rst_ni       synchronous active-low reset
//     tick_next_o  combinational look-ahead of tick_o
//     tick_o       registered one-clock tick, period M
// ---------------------------------------------------------------------------
module mod_m_counter #(
  parameter int M = 4,
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_next_o,
  output logic tick_o
);

  logic [N-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  // Wrap at M-1; the tick is registered from the wrap condition so it lands
  // in the clock after the count reaches M-1, i.e. every M-th clock.
  always_comb begin
    tick_d = (cnt_q == N'(M - 1));
    cnt_d  = tick_d ? '0 : cnt_q + N'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_next_o = tick_d;
  assign tick_o      = tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//   VGA raster timing generator feeding the pong graphics pipeline. A
//   mod_m_counter divides the system clock into a pixel enable; the H/V
//   raster counters advance once per pixel enable. hsync, vsync, video_on and
//   frame_tick are all registered from the next-state counter values so they
//   stay cycle-aligned with pix_x/pix_y.
//
//   Ports:
//     clk         system clock, rising edge
//     reset       synchronous active-low reset
//     p_tick      pixel enable, one clock wide every CLK_DIV clocks
//     frame_tick  one-clock pulse on the last pixel-enable clock of a frame
//     pix_x       horizontal count, 0..H_TOTAL-1
//     pix_y       vertical count, 0..V_TOTAL-1
//     video_on    high inside the visible H_DISP x V_DISP area
//     hsync       horizontal sync, active level SYNC_POL
//     vsync       vertical sync, active level SYNC_POL
// ---------------------------------------------------------------------------
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter bit SYNC_POL = 1'b0,
  parameter int H_DISP   = DEF_H_DISP,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_DISP   = DEF_V_DISP,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             reset,
  output logic             p_tick,
  output logic             frame_tick,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync
);

  localparam int H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_DISP + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISP + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int DIV_W    = cnt_width(CLK_DIV);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_TOTAL - 1);

  localparam vga_ctrl_t CTRL_RESET = '{video_on: 1'b0,
                                       hsync:    ~SYNC_POL,
                                       vsync:    ~SYNC_POL};

  logic             tick_next;
  logic             p_tick_q;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  vga_ctrl_t        ctrl_q, ctrl_d;
  logic             frame_q, frame_d;

  mod_m_counter #(
    .M (CLK_DIV),
    .N (DIV_W)
  ) u_pix_div (
    .clk_i       (clk),
    .rst_ni      (reset),
    .tick_next_o (tick_next),
    .tick_o      (p_tick_q)
  );

  // The raster position moves on the clock after a visible p_tick, so each
  // pixel value is held for CLK_DIV clocks with p_tick marking its last clock.
  // The sync/video/frame bits look at the next position so they change on
  // the same edge as pix_x/pix_y.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (p_tick_q) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + CNT_W'(1);
      end else begin
        x_d = x_q + CNT_W'(1);
      end
    end

    ctrl_d.video_on = (x_d < CNT_W'(H_DISP)) && (y_d < CNT_W'(V_DISP));
    ctrl_d.hsync    = in_window(x_d, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
    ctrl_d.vsync    = in_window(y_d, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;

    frame_d = tick_next && (x_d == X_LAST) && (y_d == Y_LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q     <= '0;
      y_q     <= '0;
      ctrl_q  <= CTRL_RESET;
      frame_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      ctrl_q  <= ctrl_d;
      frame_q <= frame_d;
    end
  end

  assign p_tick     = p_tick_q;
  assign frame_tick = frame_q;
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign video_on   = ctrl_q.video_on;
  assign hsync      = ctrl_q.hsync;
  assign vsync      = ctrl_q.vsync;

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//   Three generators share clock and reset: full 640x480 timing at CLK_DIV=4,
//   a shrunken raster at CLK_DIV=4, and the same shrunken raster at CLK_DIV=1
//   with active-high sync. Expected outputs come from the elapsed clock count
//   since reset release, turned into a pixel index with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

  typedef struct {
    int d;
    bit pol;
    int hDisp, hFp, hSync, hBp;
    int vDisp, vFp, vSync, vBp;
  } cfg_t;

  typedef struct {
    int x;
    int y;
    bit pTick;
    bit frameTick;
    bit videoOn;
    bit hsync;
    bit vsync;
  } outs_t;

  typedef struct {
    int    inst;
    int    t;
    outs_t exp;
  } vec_t;

  localparam cfg_t CFG0 = '{4, 1'b0, 640, 16, 96, 48, 480, 10, 2, 33};
  localparam cfg_t CFG1 = '{4, 1'b0, 40, 4, 6, 6, 20, 2, 2, 3};
  localparam cfg_t CFG2 = '{1, 1'b1, 40, 4, 6, 6, 20, 2, 2, 3};

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic       pt0, ft0, vo0, hs0, vs0;
  logic [9:0] px0, py0;
  logic       pt1, ft1, vo1, hs1, vs1;
  logic [9:0] px1, py1;
  logic       pt2, ft2, vo2, hs2, vs2;
  logic [9:0] px2, py2;

  int  checks = 0;
  int  passes = 0;
  int  t = 0;
  bit  started = 1'b0;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .CLK_DIV(CFG0.d), .SYNC_POL(CFG0.pol),
    .H_DISP(CFG0.hDisp), .H_FP(CFG0.hFp), .H_SYNC(CFG0.hSync), .H_BP(CFG0.hBp),
    .V_DISP(CFG0.vDisp), .V_FP(CFG0.vFp), .V_SYNC(CFG0.vSync), .V_BP(CFG0.vBp)
  ) dut0 (
    .clk(clk), .reset(reset), .p_tick(pt0), .frame_tick(ft0),
    .pix_x(px0), .pix_y(py0), .video_on(vo0), .hsync(hs0), .vsync(vs0)
  );

  vga_sync_gen #(
    .CLK_DIV(CFG1.d), .SYNC_POL(CFG1.pol),
    .H_DISP(CFG1.hDisp), .H_FP(CFG1.hFp), .H_SYNC(CFG1.hSync), .H_BP(CFG1.hBp),
    .V_DISP(CFG1.vDisp), .V_FP(CFG1.vFp), .V_SYNC(CFG1.vSync), .V_BP(CFG1.vBp)
  ) dut1 (
    .clk(clk), .reset(reset), .p_tick(pt1), .frame_tick(ft1),
    .pix_x(px1), .pix_y(py1), .video_on(vo1), .hsync(hs1), .vsync(vs1)
  );

  vga_sync_gen #(
    .CLK_DIV(CFG2.d), .SYNC_POL(CFG2.pol),
    .H_DISP(CFG2.hDisp), .H_FP(CFG2.hFp), .H_SYNC(CFG2.hSync), .H_BP(CFG2.hBp),
    .V_DISP(CFG2.vDisp), .V_FP(CFG2.vFp), .V_SYNC(CFG2.vSync), .V_BP(CFG2.vBp)
  ) dut2 (
    .clk(clk), .reset(reset), .p_tick(pt2), .frame_tick(ft2),
    .pix_x(px2), .pix_y(py2), .video_on(vo2), .hsync(hs2), .vsync(vs2)
  );

  // Clocks elapsed since reset was last sampled low; 0 means "in reset".
  always @(posedge clk) begin
    started <= 1'b1;
    if (!reset) t <= 0;
    else        t <= t + 1;
  end

  function automatic cfg_t cfgOf(input int inst);
    case (inst)
      0:       return CFG0;
      1:       return CFG1;
      default: return CFG2;
    endcase
  endfunction

  // Reference: after t clocks out of reset the raster has taken (t-1)/d
  // pixel steps, and p_tick fires on every d-th clock.
  function automatic outs_t model(input cfg_t c, input int tNow);
    outs_t o;
    int hTot, vTot, p, hs, vs;
    hTot = c.hDisp + c.hFp + c.hSync + c.hBp;
    vTot = c.vDisp + c.vFp + c.vSync + c.vBp;
    if (tNow == 0) begin
      o = '{0, 0, 1'b0, 1'b0, 1'b0, ~c.pol, ~c.pol};
      return o;
    end
    p = ((tNow - 1) / c.d) % (hTot * vTot);
    o.x = p % hTot;
    o.y = p / hTot;
    o.pTick = (tNow % c.d) == 0;
    o.frameTick = o.pTick && (o.x == hTot - 1) && (o.y == vTot - 1);
    o.videoOn = (o.x < c.hDisp) && (o.y < c.vDisp);
    hs = c.hDisp + c.hFp;
    vs = c.vDisp + c.vFp;
    o.hsync = ((o.x >= hs) && (o.x < hs + c.hSync)) ? c.pol : ~c.pol;
    o.vsync = ((o.y >= vs) && (o.y < vs + c.vSync)) ? c.pol : ~c.pol;
    return o;
  endfunction

  function automatic outs_t getOuts(input int inst);
    outs_t o;
    case (inst)
      0:       o = '{int'(px0), int'(py0), pt0, ft0, vo0, hs0, vs0};
      1:       o = '{int'(px1), int'(py1), pt1, ft1, vo1, hs1, vs1};
      default: o = '{int'(px2), int'(py2), pt2, ft2, vo2, hs2, vs2};
    endcase
    return o;
  endfunction

  task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act == exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s t=%0d got x=%0d y=%0d pt=%0b ft=%0b vid=%0b hs=%0b vs=%0b want x=%0d y=%0d pt=%0b ft=%0b vid=%0b hs=%0b vs=%0b",
               name, t, act.x, act.y, act.pTick, act.frameTick, act.videoOn, act.hsync, act.vsync,
               exp.x, exp.y, exp.pTick, exp.frameTick, exp.videoOn, exp.hsync, exp.vsync);
    end
  endtask

  // Every clock, every instance against the arithmetic reference.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("stream0", getOuts(0), model(CFG0, t));
      checkOutput("stream1", getOuts(1), model(CFG1, t));
      checkOutput("stream2", getOuts(2), model(CFG2, t));
    end
  end

  task automatic applyStimulus(input int clocks);
    repeat (clocks) @(negedge clk);
  endtask

  vec_t vecs[$];

  initial begin
    // Hand-derived checkpoints, ascending in t, fields {x, y, pt, ft, vid, hs, vs}.
    vecs.push_back('{0,    1, '{0,   0, 0, 0, 1, 1, 1}});
    vecs.push_back('{0,    3, '{0,   0, 0, 0, 1, 1, 1}});
    vecs.push_back('{0,    4, '{0,   0, 1, 0, 1, 1, 1}});
    vecs.push_back('{0,    5, '{1,   0, 0, 0, 1, 1, 1}});
    vecs.push_back('{2,   45, '{44,  0, 1, 0, 0, 1, 0}});
    vecs.push_back('{2,   50, '{49,  0, 1, 0, 0, 1, 0}});
    vecs.push_back('{2,   51, '{50,  0, 1, 0, 0, 0, 0}});
    vecs.push_back('{2, 1233, '{0,  22, 1, 0, 0, 0, 1}});
    vecs.push_back('{2, 1512, '{55, 26, 1, 1, 0, 0, 0}});
    vecs.push_back('{2, 1513, '{0,   0, 1, 0, 1, 0, 0}});
    vecs.push_back('{0, 2560, '{639, 0, 1, 0, 1, 1, 1}});
    vecs.push_back('{0, 2561, '{640, 0, 0, 0, 0, 1, 1}});
    vecs.push_back('{0, 2624, '{655, 0, 1, 0, 0, 1, 1}});
    vecs.push_back('{0, 2625, '{656, 0, 0, 0, 0, 0, 1}});
    vecs.push_back('{0, 3008, '{751, 0, 1, 0, 0, 0, 1}});
    vecs.push_back('{0, 3009, '{752, 0, 0, 0, 0, 1, 1}});
    vecs.push_back('{2, 3024, '{55, 26, 1, 1, 0, 0, 0}});
    vecs.push_back('{0, 3200, '{799, 0, 1, 0, 0, 1, 1}});
    vecs.push_back('{0, 3201, '{0,   1, 0, 0, 1, 1, 1}});
    vecs.push_back('{1, 4929, '{0,  22, 0, 0, 0, 1, 0}});
    vecs.push_back('{1, 5376, '{55, 23, 1, 0, 0, 1, 0}});
    vecs.push_back('{1, 5377, '{0,  24, 0, 0, 0, 1, 1}});
    vecs.push_back('{1, 6048, '{55, 26, 1, 1, 0, 1, 1}});
    vecs.push_back('{1, 6049, '{0,   0, 0, 0, 1, 1, 1}});

    // Reset held for five clocks; outputs must sit at reset values.
    reset = 1'b0;
    applyStimulus(5);
    checkOutput("rst_vals0", getOuts(0), '{0, 0, 0, 0, 0, 1, 1});
    checkOutput("rst_vals2", getOuts(2), '{0, 0, 0, 0, 0, 0, 0});
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      int guard = 0;
      while (t < vecs[i].t && guard < 20000) begin
        @(negedge clk);
        guard++;
      end
      if (t != vecs[i].t) begin
        checks++;
        $display("[TB] FAIL vec%0d_time got t=%0d want t=%0d", i, t, vecs[i].t);
      end else begin
        checkOutput($sformatf("vec%0d", i), getOuts(vecs[i].inst), vecs[i].exp);
      end
    end

    // Single-clock reset in the middle of a frame, then a clean restart.
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("midrst0", getOuts(0), '{0, 0, 0, 0, 0, 1, 1});
    checkOutput("midrst1", getOuts(1), '{0, 0, 0, 0, 0, 1, 1});
    reset = 1'b1;
    applyStimulus(3);
    checkOutput("restart_t3", getOuts(0), '{0, 0, 0, 0, 1, 1, 1});
    applyStimulus(1);
    checkOutput("restart_t4", getOuts(0), '{0, 0, 1, 0, 1, 1, 1});

    // Random run lengths and reset pulses, checked by the streaming model.
    for (int i = 0; i < 6; i++) begin
      applyStimulus($urandom_range(200, 3000));
      reset = 1'b0;
      applyStimulus($urandom_range(1, 3));
      reset = 1'b1;
    end
    applyStimulus(2000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
